round_timer_ctrl: RTL and testbench
===================================

// Module: round_timer_ctrl
// PURPOSE
//   Multi-round match timer: PREP countdown, then NUM_ROUNDS fight rounds separated by REST periods, then DONE.
//   Counts in mm:ss from a clock-enable prescaler. No derived clocks; everything runs on i_clk.
//   Drives the display digits, the phase indicator and the round number for the game controller.
// PARAMETERS
//   TICK_DIV    100_000_000  i_clk cycles per second tick (>=2)
//   PREP_SEC    5            prep countdown length, seconds (>=1)
//   ROUND_SEC   90           round length, seconds (>=1)
//   REST_SEC    30           rest length between rounds, seconds; 0 = no REST phase
//   NUM_ROUNDS  3            rounds per match (>=1)
//   MIN_W       4            minutes field width; each *_SEC <= 60*2^MIN_W-1
// PORTS
//   i_clk          in   1          system clock
//   i_reset_n      in   1          asynchronous active-low reset
//   i_start        in   1          1-cycle pulse: (re)start match from PREP
//   i_pause        in   1          level: freeze countdown while high
//   i_abort        in   1          1-cycle pulse: return to IDLE
//   o_min          out  MIN_W      minutes remaining in current phase
//   o_sec          out  6          seconds remaining (0..59)
//   o_phase        out  3          0 IDLE, 1 PREP, 2 ROUND, 3 REST, 4 DONE
//   o_round_num    out  RND_W      current round, 1..NUM_ROUNDS; 0 in IDLE. RND_W=$clog2(NUM_ROUNDS+1)
//   o_tick         out  1          1-cycle pulse on every counted second
//   o_phase_done   out  1          1-cycle pulse on the tick that ends a phase
//   o_match_done   out  1          high while in DONE
// BEHAVIOUR
//   - Reset (async assert, sync-deasserted by caller): phase IDLE, prescaler 0, o_min:o_sec = PREP_SEC as mm:ss,
//     o_round_num 0, all pulses 0, o_match_done 0. IDLE after i_abort holds the same values.
//   - Prescaler runs only in PREP/ROUND/REST with i_pause low; holds its value otherwise.
//     Tick when prescaler == TICK_DIV-1, which clears the prescaler to 0.
//     i_start clears it to 0, so the first tick comes TICK_DIV cycles after start.
//   - On tick with time != 0:00: decrement by 1 s; sec 0 -> 59 with min-1. Pulse o_tick.
//   - On tick with time == 0:00: phase ends, so 0:00 is shown for one full second.
//     Pulse o_tick and o_phase_done, then take the transition:
//       PREP  -> ROUND, load ROUND_SEC, round 1
//       ROUND -> DONE if round==NUM_ROUNDS (time holds 0:00)
//                else REST, load REST_SEC; if REST_SEC==0, straight to ROUND with round+1
//       REST  -> ROUND, load ROUND_SEC, round+1
//   - Phase length is therefore (N+1)*TICK_DIV cycles for a load of N seconds.
//   - i_start in any phase: next edge goes to PREP, loads PREP_SEC, round 1, prescaler 0.
//     o_phase_done is not pulsed.
//   - i_abort: next edge goes to IDLE with reset values. Abort wins over start in the same cycle.
//   - i_pause high: time, prescaler and phase frozen. No effect in IDLE/DONE.
//     Start while paused loads PREP and stays frozen until pause drops.
//   - DONE holds until i_start or i_abort. o_match_done = (phase==DONE).
//   - All outputs registered; state updates on the edge after the input/tick condition.
//   - Time load values are elaboration constants: min = SEC/60, sec = SEC%60.
// TESTING  (TICK_DIV=4, PREP_SEC=2, ROUND_SEC=3, REST_SEC=1, NUM_ROUNDS=2)
//   1. Reset low -> phase 0, 0:02, round 0, o_tick 0. Start, run -> PREP 2,1,0 / ROUND 3..0 / REST 1,0 / ROUND 3..0.
//      o_match_done rises 52 cycles after the start edge; o_phase_done pulses 4 times; round_num 1,1,2.
//   2. Pause high for 10 cycles mid-ROUND at 0:02 -> o_sec stays 2, no o_tick; DONE arrives exactly 10 cycles late.
//   3. Start asserted during REST -> next cycle PREP, 0:02, round 1, no o_phase_done; first tick 4 cycles later.
//   4. i_start and i_abort in the same cycle during ROUND -> IDLE, 0:02, round 0. Reset asserted mid-ROUND -> same values.
//   5. REST_SEC=0 build -> ROUND1 end goes directly to ROUND, 3 s, round 2; DONE 44 cycles after start.
//   6. ROUND_SEC=61 -> 1:01, 1:00, 0:59 on successive ticks (minute borrow).

Source files
------------

// File: rtl/round_timer_ctrl.sv
// Multi-round match timer: PREP countdown, NUM_ROUNDS fight rounds with optional REST gaps, then DONE.
// Time is kept as mm:ss and advanced by a clock-enable prescaler on i_clk.
module round_timer_ctrl #(
   parameter int TICK_DIV   = 100_000_000,
   parameter int PREP_SEC   = 5,
   parameter int ROUND_SEC  = 90,
   parameter int REST_SEC   = 30,
   parameter int NUM_ROUNDS = 3,
   parameter int MIN_W      = 4,
   localparam int RND_W     = $clog2(NUM_ROUNDS + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_abort,
   output logic [MIN_W-1:0] o_min,
   output logic [5:0]       o_sec,
   output logic [2:0]       o_phase,
   output logic [RND_W-1:0] o_round_num,
   output logic             o_tick,
   output logic             o_phase_done,
   output logic             o_match_done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [MIN_W-1:0] PREP_MIN  = MIN_W'(PREP_SEC / 60);
   localparam logic [5:0]       PREP_S    = 6'(PREP_SEC % 60);
   localparam logic [MIN_W-1:0] ROUND_MIN = MIN_W'(ROUND_SEC / 60);
   localparam logic [5:0]       ROUND_S   = 6'(ROUND_SEC % 60);
   localparam logic [MIN_W-1:0] REST_MIN  = MIN_W'(REST_SEC / 60);
   localparam logic [5:0]       REST_S    = 6'(REST_SEC % 60);
   localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS);

   // Encoding doubles as the o_phase value.
   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_PREP  = 3'd1,
      PH_ROUND = 3'd2,
      PH_REST  = 3'd3,
      PH_DONE  = 3'd4
   } phase_t;

   phase_t           phase, phase_nxt;
   logic [PW-1:0]    presc, presc_nxt;
   logic [MIN_W-1:0] min_nxt;
   logic [5:0]       sec_nxt;
   logic [RND_W-1:0] round_nxt;
   logic             tick_nxt, pdone_nxt;
   logic             running, tick_hit, time_zero;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase        <= PH_IDLE;
         presc        <= '0;
         o_min        <= PREP_MIN;
         o_sec        <= PREP_S;
         o_round_num  <= '0;
         o_tick       <= 1'b0;
         o_phase_done <= 1'b0;
         o_match_done <= 1'b0;
      end else begin
         phase        <= phase_nxt;
         presc        <= presc_nxt;
         o_min        <= min_nxt;
         o_sec        <= sec_nxt;
         o_round_num  <= round_nxt;
         o_tick       <= tick_nxt;
         o_phase_done <= pdone_nxt;
         o_match_done <= (phase_nxt == PH_DONE);
      end
   end

   assign o_phase = phase;

   always_comb begin
      phase_nxt = phase;
      presc_nxt = presc;
      min_nxt   = o_min;
      sec_nxt   = o_sec;
      round_nxt = o_round_num;
      tick_nxt  = 1'b0;
      pdone_nxt = 1'b0;

      running   = ((phase == PH_PREP) || (phase == PH_ROUND) || (phase == PH_REST)) && !i_pause;
      tick_hit  = running && (presc == TICK_LAST);
      time_zero = (o_min == '0) && (o_sec == 6'd0);

      // Abort beats start; start beats the tick in the same cycle.
      if (i_abort) begin
         phase_nxt = PH_IDLE;
         presc_nxt = '0;
         min_nxt   = PREP_MIN;
         sec_nxt   = PREP_S;
         round_nxt = '0;
      end else if (i_start) begin
         phase_nxt = PH_PREP;
         presc_nxt = '0;
         min_nxt   = PREP_MIN;
         sec_nxt   = PREP_S;
         round_nxt = RND_W'(1);
      end else if (tick_hit) begin
         presc_nxt = '0;
         tick_nxt  = 1'b1;
         if (time_zero) begin
            pdone_nxt = 1'b1;
            case (phase)
               PH_PREP: begin
                  phase_nxt = PH_ROUND;
                  min_nxt   = ROUND_MIN;
                  sec_nxt   = ROUND_S;
                  round_nxt = RND_W'(1);
               end
               PH_ROUND: begin
                  if (o_round_num == LAST_RND) begin
                     phase_nxt = PH_DONE;
                  end else if (REST_SEC == 0) begin
                     phase_nxt = PH_ROUND;
                     min_nxt   = ROUND_MIN;
                     sec_nxt   = ROUND_S;
                     round_nxt = o_round_num + RND_W'(1);
                  end else begin
                     phase_nxt = PH_REST;
                     min_nxt   = REST_MIN;
                     sec_nxt   = REST_S;
                  end
               end
               PH_REST: begin
                  phase_nxt = PH_ROUND;
                  min_nxt   = ROUND_MIN;
                  sec_nxt   = ROUND_S;
                  round_nxt = o_round_num + RND_W'(1);
               end
               default: ;
            endcase
         end else if (o_sec == 6'd0) begin
            sec_nxt = 6'd59;
            min_nxt = o_min - MIN_W'(1);
         end else begin
            sec_nxt = o_sec - 6'd1;
         end
      end else if (running) begin
         presc_nxt = presc + PW'(1);
      end
   end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: vector table, hand sequences and random stimulus against a schedule-based model.
// Three builds share the inputs: baseline, no-REST, and 61 s rounds (minute borrow).
module tb_round_timer_ctrl;

   localparam int TD   = 4;
   localparam int PREP = 2;
   localparam int NR   = 2;
   int p_rnd  [3] = '{3, 3, 61};
   int p_rest [3] = '{1, 0, 1};

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic i_start = 1'b0, i_pause = 1'b0, i_abort = 1'b0;

   logic [3:0] mn_o [3];
   logic [5:0] sc_o [3];
   logic [2:0] ph_o [3];
   logic [1:0] rn_o [3];
   logic       tk_o [3];
   logic       pd_o [3];
   logic       md_o [3];

   int total = 0;
   int bad = 0;

   always #5 i_clk = ~i_clk;

   round_timer_ctrl #(.TICK_DIV(TD), .PREP_SEC(PREP), .ROUND_SEC(3), .REST_SEC(1), .NUM_ROUNDS(NR), .MIN_W(4)) dut_base (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_pause(i_pause), .i_abort(i_abort),
      .o_min(mn_o[0]), .o_sec(sc_o[0]), .o_phase(ph_o[0]), .o_round_num(rn_o[0]),
      .o_tick(tk_o[0]), .o_phase_done(pd_o[0]), .o_match_done(md_o[0]));

   round_timer_ctrl #(.TICK_DIV(TD), .PREP_SEC(PREP), .ROUND_SEC(3), .REST_SEC(0), .NUM_ROUNDS(NR), .MIN_W(4)) dut_norest (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_pause(i_pause), .i_abort(i_abort),
      .o_min(mn_o[1]), .o_sec(sc_o[1]), .o_phase(ph_o[1]), .o_round_num(rn_o[1]),
      .o_tick(tk_o[1]), .o_phase_done(pd_o[1]), .o_match_done(md_o[1]));

   round_timer_ctrl #(.TICK_DIV(TD), .PREP_SEC(PREP), .ROUND_SEC(61), .REST_SEC(1), .NUM_ROUNDS(NR), .MIN_W(4)) dut_long (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_pause(i_pause), .i_abort(i_abort),
      .o_min(mn_o[2]), .o_sec(sc_o[2]), .o_phase(ph_o[2]), .o_round_num(rn_o[2]),
      .o_tick(tk_o[2]), .o_phase_done(pd_o[2]), .o_match_done(md_o[2]));

   // The match is a list of segments (PREP, ROUND, REST, ...); each N-second segment lasts N+1 seconds.
   // Given completed seconds s, find the segment, remaining time and round; idx = segment count means DONE.
   function automatic void lookup(input int k, input int s, output int ph, output int rem,
                                  output int rn, output int idx);
      int len [$];
      int kind [$];
      int rnd [$];
      int b;
      len.push_back(PREP); kind.push_back(1); rnd.push_back(1);
      for (int r = 1; r <= NR; r++) begin
         len.push_back(p_rnd[k]); kind.push_back(2); rnd.push_back(r);
         if (r < NR && p_rest[k] > 0) begin
            len.push_back(p_rest[k]); kind.push_back(3); rnd.push_back(r);
         end
      end
      ph = 4; rem = 0; rn = NR; idx = len.size(); b = 0;
      for (int i = 0; i < len.size(); i++) begin
         if (s < b + len[i] + 1) begin
            ph = kind[i]; rem = len[i] - (s - b); rn = rnd[i]; idx = i;
            break;
         end
         b += len[i] + 1;
      end
   endfunction

   // Model state: whether a match is active and how many unpaused cycles it has run.
   bit m_act [3];
   int m_el [3];
   bit m_tick [3];
   bit m_pd [3];

   always @(posedge i_clk) begin : model
      int ph, rem, rn, idx0, idx1;
      logic [17:0] exp_v, act_v;
      for (int k = 0; k < 3; k++) begin
         m_tick[k] = 1'b0;
         m_pd[k] = 1'b0;
         if (!i_reset_n || i_abort) begin
            m_act[k] = 1'b0; m_el[k] = 0;
         end else if (i_start) begin
            m_act[k] = 1'b1; m_el[k] = 0;
         end else if (m_act[k] && !i_pause) begin
            lookup(k, m_el[k] / TD, ph, rem, rn, idx0);
            if (ph != 4) begin
               m_el[k]++;
               if (m_el[k] % TD == 0) begin
                  m_tick[k] = 1'b1;
                  lookup(k, m_el[k] / TD, ph, rem, rn, idx1);
                  m_pd[k] = (idx1 != idx0);
               end
            end
         end
      end
      #2;
      for (int k = 0; k < 3; k++) begin
         if (!m_act[k]) begin
            exp_v = {3'd0, 4'd0, 6'(PREP), 2'd0, 1'b0, 1'b0, 1'b0};
         end else begin
            lookup(k, m_el[k] / TD, ph, rem, rn, idx0);
            exp_v = {3'(ph), 4'(rem / 60), 6'(rem % 60), 2'(rn), m_tick[k], m_pd[k], (ph == 4)};
         end
         act_v = {ph_o[k], mn_o[k], sc_o[k], rn_o[k], tk_o[k], pd_o[k], md_o[k]};
         total++;
         if (act_v !== exp_v) begin
            bad++;
            $display("[TB] FAIL model dut%0d @%0t got ph=%0d %0d:%0d rnd=%0d tick=%0d pd=%0d md=%0d want ph=%0d %0d:%0d rnd=%0d tick=%0d pd=%0d md=%0d",
                     k, $time, act_v[17:15], act_v[14:11], act_v[10:5], act_v[4:3], act_v[2], act_v[1], act_v[0],
                     exp_v[17:15], exp_v[14:11], exp_v[10:5], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
   end

   typedef struct {
      bit st, pa, ab;
      int cyc;
      int ph, mn, sc, rn, md;
   } vec_t;
   vec_t tbl [$];

   task automatic add_vec(input bit st, pa, ab, input int cyc, ph, mn, sc, rn, md);
      vec_t v;
      v.st = st; v.pa = pa; v.ab = ab; v.cyc = cyc;
      v.ph = ph; v.mn = mn; v.sc = sc; v.rn = rn; v.md = md;
      tbl.push_back(v);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic apply_stimulus(input bit st, pa, ab, input int n);
      i_start = st; i_pause = pa; i_abort = ab;
      cyc(n);
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s @%0t got %0d want %0d", name, $time, act, exp);
      end
   endtask

   initial begin
      // start, pause, abort, cycles, phase, min, sec, round, match_done
      add_vec(0,0,0, 1,  0,0,2,0,0);
      add_vec(1,0,0, 1,  1,0,2,1,0);
      add_vec(0,0,0, 4,  1,0,1,1,0);
      add_vec(0,0,0, 8,  2,0,3,1,0);
      add_vec(0,0,0, 16, 3,0,1,1,0);
      add_vec(0,0,0, 8,  2,0,3,2,0);
      add_vec(0,0,0, 15, 2,0,0,2,0);
      add_vec(0,0,0, 1,  4,0,0,2,1);
      add_vec(0,0,0, 5,  4,0,0,2,1);
      add_vec(0,0,1, 1,  0,0,2,0,0);
      add_vec(1,0,0, 1,  1,0,2,1,0);
      add_vec(0,0,0, 16, 2,0,2,1,0);
      add_vec(0,1,0, 10, 2,0,2,1,0);
      add_vec(0,0,0, 35, 2,0,0,2,0);
      add_vec(0,0,0, 1,  4,0,0,2,1);
      add_vec(1,0,0, 1,  1,0,2,1,0);
      add_vec(0,0,0, 29, 3,0,1,1,0);
      add_vec(1,0,0, 1,  1,0,2,1,0);
      add_vec(0,0,0, 3,  1,0,2,1,0);
      add_vec(0,0,0, 1,  1,0,1,1,0);
      add_vec(0,0,0, 9,  2,0,3,1,0);
      add_vec(1,0,1, 1,  0,0,2,0,0);
      add_vec(0,1,0, 5,  0,0,2,0,0);
      add_vec(1,1,0, 1,  1,0,2,1,0);
      add_vec(0,1,0, 8,  1,0,2,1,0);
      add_vec(0,0,0, 4,  1,0,1,1,0);

      repeat (3) @(posedge i_clk);
      #1;
      check_output("reset_phase", ph_o[0], 0);
      check_output("reset_sec", sc_o[0], 2);
      check_output("reset_tick", tk_o[0], 0);
      i_reset_n = 1'b1;

      foreach (tbl[i]) begin
         apply_stimulus(tbl[i].st, tbl[i].pa, tbl[i].ab, tbl[i].cyc);
         check_output($sformatf("vec%0d_phase", i), ph_o[0], tbl[i].ph);
         check_output($sformatf("vec%0d_min", i), mn_o[0], tbl[i].mn);
         check_output($sformatf("vec%0d_sec", i), sc_o[0], tbl[i].sc);
         check_output($sformatf("vec%0d_round", i), rn_o[0], tbl[i].rn);
         check_output($sformatf("vec%0d_done", i), md_o[0], tbl[i].md);
      end

      // Without REST the match ends 44 cycles after the start edge.
      apply_stimulus(1, 0, 0, 1);
      apply_stimulus(0, 0, 0, 43);
      check_output("norest_not_done", md_o[1], 0);
      apply_stimulus(0, 0, 0, 1);
      check_output("norest_done", md_o[1], 1);

      // 61 s rounds: 1:01, 1:00, 0:59.
      apply_stimulus(1, 0, 0, 1);
      apply_stimulus(0, 0, 0, 12);
      check_output("long_t0", mn_o[2] * 60 + sc_o[2], 61);
      check_output("long_t0_sec", sc_o[2], 1);
      apply_stimulus(0, 0, 0, 4);
      check_output("long_t1_min", mn_o[2], 1);
      check_output("long_t1_sec", sc_o[2], 0);
      apply_stimulus(0, 0, 0, 4);
      check_output("long_t2_min", mn_o[2], 0);
      check_output("long_t2_sec", sc_o[2], 59);

      // Reset asserted mid-ROUND takes effect before the next edge.
      apply_stimulus(1, 0, 0, 1);
      apply_stimulus(0, 0, 0, 20);
      check_output("pre_reset_phase", ph_o[0], 2);
      #2;
      i_reset_n = 1'b0;
      #1;
      check_output("async_reset_phase", ph_o[0], 0);
      check_output("async_reset_sec", sc_o[0], 2);
      check_output("async_reset_round", rn_o[0], 0);
      @(posedge i_clk);
      @(posedge i_clk);
      #3;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      for (int n = 0; n < 4000; n++) begin
         i_start = ($urandom_range(0, 79) == 0);
         i_abort = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 24) == 0) i_pause = ~i_pause;
         cyc(1);
      end
      apply_stimulus(0, 0, 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
